wb_imem: RTL and testbench
==========================

# wb_imem

Wishbone classic responder that serves 16-bit instruction memory to the mox125 fetch path. It sits on the far side of the instruction cache's line-fill bus: it accepts one halfword access per strobe, inserts a programmable number of wait states and returns a single-cycle acknowledge. A mandatory idle cycle after every acknowledge matches the fill engine's ack/wait rhythm, so a strobe held high across a 16-beat line fill never loses a beat. Writes are supported so a loader or debug master can populate the memory.

## Interface
- `AW`, default 12: halfword address bits; memory depth is 2^AW halfwords (default 4096 = 8 KB).
- `WAIT_STATES`, default 1: cycles inserted between request capture and acknowledge (0..15).
- `BASE_ADR`, default 32'h0000_0000: byte base of the memory window; must be aligned to 2^(AW+1).
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `wb_adr_i`  in  32  byte address.
- `wb_dat_i`  in  16  write data.
- `wb_sel_i`  in  2  byte lane enables: [1] = bits 15:8, [0] = bits 7:0.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_cyc_i`  in  1  bus cycle active.
- `wb_stb_i`  in  1  strobe.
- `wb_dat_o`  out  16  read data; valid in the `wb_ack_o` cycle.
- `wb_ack_o`  out  1  normal termination, one-cycle pulse.
- `wb_err_o`  out  1  error termination, one-cycle pulse.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: when `wb_cyc_i & wb_stb_i`, capture the address, data, sel and we inputs.
  - Go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0; otherwise go to RESP.
  - Otherwise stay in IDLE.
- WAIT: decrement the counter and go to RESP when it reaches 0.
  - If `wb_cyc_i` or `wb_stb_i` is low, abort to IDLE: no ack, no err, no write.
- RESP: assert exactly one of `wb_ack_o`/`wb_err_o` for one cycle, then go unconditionally to IDLE. Acks are therefore separated by at least one low cycle.
- Decode, using captured values:
  - in_range = adr[31:AW+1] == BASE_ADR[31:AW+1].
  - Index = adr[AW:1].
  - Error if !in_range or adr[0] = 1.
- Read with no error: `wb_dat_o` = mem[index], registered on entry to RESP. It holds its value outside RESP.
- Write with no error: the lanes selected by `wb_sel_i` are written on the RESP transition. Unselected lanes are unchanged. sel = 2'b00 is acked and writes nothing.
- Error: memory is untouched and `wb_dat_o` is unchanged.
- Memory contents are not affected by reset.

## Timing
- Reset values: `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 16'h0000, state IDLE, counter 0.
- Assertion of `rst_ni` clears the outputs immediately (asynchronously), including mid-WAIT or mid-RESP. A write in flight is dropped.
- Latency from the capturing edge in IDLE to the ack cycle is WAIT_STATES+1 cycles.
- Back-to-back requests take WAIT_STATES+2 cycles per access.
- With WAIT_STATES = 0 and the strobe held high (address updated on the ack edge):
  - ack in cycles t, t+2, t+4, …
  - the address presented in cycle t+1 is the one served at t+2.
- `wb_ack_o` and `wb_err_o` are never high in the same cycle and never high in consecutive cycles.
- Input changes during WAIT, other than cyc/stb dropping, are ignored.

## Test plan
- Write then read, WAIT_STATES = 1: write 16'hBEEF at 0x0000_0010 with sel 2'b11, then read the same address. Required: ack 2 cycles after capture; `wb_dat_o` = 16'hBEEF in the ack cycle.
- Partial write: preload 16'h1234 at 0x20, write 16'hAB00 with sel 2'b10, then read. Required: 16'hAB34.
- Line-fill burst, WAIT_STATES = 0: preload 0x0100..0x011E with halfwords 0..15. Drive a master that holds stb high, adds 2 to the address on each ack and ignores the cycle after each ack. Required:
  - exactly 16 acks, each 2 cycles apart;
  - data sequence 0..15;
  - no err.
- Error cases:
  - read 0x0000_4000 with AW = 12, BASE_ADR = 0: `wb_err_o` pulse, no ack, `wb_dat_o` unchanged;
  - read 0x0000_0003 (misaligned): err.
- Abort: WAIT_STATES = 3, issue a write of 16'h5555 to 0x40, drop cyc after 1 cycle. Required: no ack or err, and a later read of 0x40 returns the prior value.
- Reset mid-WAIT: assert `rst_ni` low during WAIT. Required: `wb_ack_o` and `wb_err_o` low the same cycle; after release, a new read completes normally.

Source files
------------

// File: rtl/wb_imem.sv
// wb_imem: Wishbone classic responder serving 16-bit instruction memory.
// One halfword per strobe, WAIT_STATES wait cycles, single-cycle ack/err,
// and a guaranteed idle cycle after every termination so a master that holds
// strobe high through a line fill gets one beat every WAIT_STATES+2 cycles.
// Memory is organised as two byte-lane arrays so lane-masked writes map onto
// plain block RAM with a registered read port.
module wb_imem #(
  parameter int          AW          = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] adr_reg;
  logic [15:0] wdat_reg;
  logic [1:0]  sel_reg;
  logic        we_reg;
  logic        ack_reg;
  logic        err_reg;
  logic        dat_valid_reg;

  // Request view: live bus inputs while idle (the capturing edge may already
  // be the RESP entry when WAIT_STATES is 0), captured copies afterwards so
  // input changes during WAIT are ignored.
  logic          req;
  logic          in_idle;
  logic [31:0]   cur_adr;
  logic [15:0]   cur_dat;
  logic [1:0]    cur_sel;
  logic          cur_we;
  logic          in_range;
  logic          dec_err;
  logic [AW-1:0] mem_idx;
  logic          enter_resp;
  logic          rd_en;
  logic [1:0]    wr_en;

  assign req     = wb_cyc_i & wb_stb_i;
  assign in_idle = (state_reg == ST_IDLE);
  assign cur_adr = in_idle ? wb_adr_i : adr_reg;
  assign cur_dat = in_idle ? wb_dat_i : wdat_reg;
  assign cur_sel = in_idle ? wb_sel_i : sel_reg;
  assign cur_we  = in_idle ? wb_we_i  : we_reg;

  assign in_range = (cur_adr[31:AW+1] == BASE_ADR[31:AW+1]);
  assign dec_err  = ~in_range | cur_adr[0];
  assign mem_idx  = cur_adr[AW:1];

  // The access completes on the edge that moves the FSM into RESP; a dropped
  // cyc/stb during WAIT never reaches this point, so aborts touch nothing.
  assign enter_resp = req & ((in_idle & (WAIT_STATES == 0)) |
                             ((state_reg == ST_WAIT) & (cnt_reg == 4'd0)));
  assign rd_en = enter_resp & ~dec_err & ~cur_we;
  assign wr_en = {2{enter_resp & ~dec_err & cur_we}} & cur_sel;

  // Control FSM with registered ack/err pulses and the read-data valid flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      adr_reg       <= 32'd0;
      wdat_reg      <= 16'd0;
      sel_reg       <= 2'b00;
      we_reg        <= 1'b0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      dat_valid_reg <= 1'b0;
    end else begin
      ack_reg <= enter_resp & ~dec_err;
      err_reg <= enter_resp & dec_err;
      if (rd_en) begin
        dat_valid_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            adr_reg  <= wb_adr_i;
            wdat_reg <= wb_dat_i;
            sel_reg  <= wb_sel_i;
            we_reg   <= wb_we_i;
            if (WAIT_STATES == 0) begin
              state_reg <= ST_RESP;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // One byte-wide memory per lane; contents deliberately survive reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Lane write on the RESP entry edge, registered read for the same edge.
    always_ff @(posedge clk_i) begin
      if (wr_en[gi]) begin
        mem[mem_idx] <= cur_dat[gi*8 +: 8];
      end
      if (rd_en) begin
        rd_q <= mem[mem_idx];
      end
    end
  end

  // Read data holds the last successful read; forced to zero until the first
  // read after reset so the output reflects reset immediately.
  assign wb_dat_o = dat_valid_reg ? {g_lane[1].rd_q, g_lane[0].rd_q} : 16'h0000;
  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;

endmodule

// File: tb/tb_wb_imem.sv
// tb_wb_imem: directed checks of wb_imem with three instances
// (WAIT_STATES = 1, 0, 3) sharing one clock and reset.
module tb_wb_imem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr  [3];
  logic [15:0] dati [3];
  logic [1:0]  sel  [3];
  logic        we   [3];
  logic        cyc  [3];
  logic        stb  [3];
  logic [15:0] dato [3];
  logic        ack  [3];
  logic        err  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    wb_imem #(
      .AW(12),
      .WAIT_STATES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3)),
      .BASE_ADR(32'h0000_0000)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .wb_adr_i(adr[gi]),
      .wb_dat_i(dati[gi]),
      .wb_sel_i(sel[gi]),
      .wb_we_i (we[gi]),
      .wb_cyc_i(cyc[gi]),
      .wb_stb_i(stb[gi]),
      .wb_dat_o(dato[gi]),
      .wb_ack_o(ack[gi]),
      .wb_err_o(err[gi])
    );
  end

  // Protocol monitor per instance: ack/err never together, never back to back.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    int   viol = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
      if (ack[gi] && err[gi]) viol <= viol + 1;
      else if ((ack[gi] || err[gi]) && prev_busy) viol <= viol + 1;
      prev_busy <= ack[gi] | err[gi];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete single access; returns sampled termination and latency.
  task automatic access(input int k, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] s, input logic w,
                        output logic [15:0] rd, output logic ga, output logic ge,
                        output int lat);
    adr[k] = a; dati[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1; stb[k] = 1'b1;
    ga = 1'b0; ge = 1'b0; lat = 0; rd = 16'h0000;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack[k] || err[k]) begin
        ga = ack[k]; ge = err[k]; rd = dato[k]; lat = i;
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    $display("dut%0d %s adr=%08h wdat=%04h sel=%b -> ack=%0b err=%0b rdat=%04h lat=%0d",
             k, w ? "WR" : "RD", a, d, s, ga, ge, rd, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] rd;
    logic        ga, ge;
    int          lat;
    int          n_ack, n_err, bad_gap, last_cyc, extra;
    logic [15:0] burst [16];

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adr[k] = 32'd0; dati[k] = 16'd0; sel[k] = 2'b00;
      we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", ack[0], 1'b0);
    check("reset_err", err[0], 1'b0);
    check("reset_dat", dato[0], 16'h0000);
    check("reset_dat_ws3", dato[2], 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read, WAIT_STATES = 1
    access(0, 32'h0000_0010, 16'hBEEF, 2'b11, 1'b1, rd, ga, ge, lat);
    check("wr_ack", ga, 1'b1);
    check("wr_err", ge, 1'b0);
    check("wr_lat", lat, 2);
    access(0, 32'h0000_0010, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("rd_ack", ga, 1'b1);
    check("rd_lat", lat, 2);
    check("rd_data", rd, 16'hBEEF);

    // Partial write: upper lane only
    access(0, 32'h0000_0020, 16'h1234, 2'b11, 1'b1, rd, ga, ge, lat);
    access(0, 32'h0000_0020, 16'hAB00, 2'b10, 1'b1, rd, ga, ge, lat);
    check("pw_ack", ga, 1'b1);
    access(0, 32'h0000_0020, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("pw_data", rd, 16'hAB34);

    // sel = 00 write: acked, memory unchanged
    access(0, 32'h0000_0020, 16'hFFFF, 2'b00, 1'b1, rd, ga, ge, lat);
    check("sel0_ack", ga, 1'b1);
    access(0, 32'h0000_0020, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("sel0_data", rd, 16'hAB34);

    // Out of range read: err, no ack, data held
    access(0, 32'h0000_4000, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("oor_err", ge, 1'b1);
    check("oor_ack", ga, 1'b0);
    check("oor_lat", lat, 2);
    check("oor_dat_held", rd, 16'hAB34);
    // Misaligned read: err
    access(0, 32'h0000_0003, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("mis_err", ge, 1'b1);
    check("mis_ack", ga, 1'b0);
    // Out of range write must not alias onto index 0x10
    access(0, 32'h0000_2010, 16'h0BAD, 2'b11, 1'b1, rd, ga, ge, lat);
    check("oorw_err", ge, 1'b1);
    access(0, 32'h0000_0010, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("oorw_data", rd, 16'hBEEF);

    // Abort, WAIT_STATES = 3
    access(2, 32'h0000_0040, 16'h7777, 2'b11, 1'b1, rd, ga, ge, lat);
    check("ws3_lat", lat, 4);
    adr[2] = 32'h0000_0040; dati[2] = 16'h5555; sel[2] = 2'b11; we[2] = 1'b1;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack[2] || err[2]) extra++;
    end
    $display("dut2 WR adr=00000040 wdat=5555 aborted, terminations seen=%0d", extra);
    check("abort_no_term", extra, 0);
    access(2, 32'h0000_0040, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("abort_data", rd, 16'h7777);

    // Line-fill burst, WAIT_STATES = 0
    for (int i = 0; i < 16; i++) begin
      access(1, 32'h0000_0100 + 32'(2 * i), 16'(i), 2'b11, 1'b1, rd, ga, ge, lat);
    end
    check("ws0_lat", lat, 1);
    n_ack = 0; n_err = 0; bad_gap = 0; last_cyc = 0;
    adr[1] = 32'h0000_0100; we[1] = 1'b0; sel[1] = 2'b11; cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int c = 1; c <= 80 && n_ack < 16; c++) begin
      @(posedge clk); #1;
      if (err[1]) n_err++;
      if (ack[1]) begin
        burst[n_ack] = dato[1];
        if (n_ack == 0 && c != 1) bad_gap++;
        if (n_ack > 0 && (c - last_cyc) != 2) bad_gap++;
        last_cyc = c;
        n_ack++;
        adr[1] = adr[1] + 32'd2;
      end
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    $display("dut1 burst adr=00000100 acks=%0d errs=%0d bad_gaps=%0d", n_ack, n_err, bad_gap);
    @(posedge clk); #1;
    check("burst_acks", n_ack, 16);
    check("burst_errs", n_err, 0);
    check("burst_gaps", bad_gap, 0);
    for (int i = 0; i < 16 && i < n_ack; i++) begin
      check($sformatf("burst_data%0d", i), burst[i], 32'(i));
    end

    // Reset mid-WAIT during a write on the WAIT_STATES = 3 instance
    adr[2] = 32'h0000_0040; dati[2] = 16'h9999; sel[2] = 2'b11; we[2] = 1'b1;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack", ack[2], 1'b0);
    check("rst_err", err[2], 1'b0);
    check("rst_dat_async", dato[2], 16'h0000);
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    $display("dut2 WR adr=00000040 wdat=9999 interrupted by reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(2, 32'h0000_0040, 16'h0000, 2'b11, 1'b0, rd, ga, ge, lat);
    check("post_rst_ack", ga, 1'b1);
    check("post_rst_lat", lat, 4);
    check("post_rst_data", rd, 16'h7777);

    check("mon0", g_mon[0].viol, 0);
    check("mon1", g_mon[1].viol, 0);
    check("mon2", g_mon[2].viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
